// File: rtl/inst_sram_pkg.sv
// Shared types, constants and address-check helpers for the instruction SRAM responder.
package inst_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
  localparam logic [31:0] NOP_INST     = 32'h00000000;
  localparam int unsigned MAX_WAIT     = 15;

  // Offset is taken with 32-bit wrap, so addresses below the base land far out of range.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned addr_w);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> (addr_w + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/inst_sram_responder_rom.sv
// Synchronous-read instruction array, cleared to NOP at elaboration.
module inst_rom
  import inst_sram_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = "inst_rom.mif"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  output logic [31:0]       dout
);

  logic [31:0] mem [2**ADDR_W];

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = NOP_INST;
  end

  // Output register holds its word until the next enabled read.
  always_ff @(posedge clk) begin
    if (reset) dout <= 32'd0;
    else if (re) dout <= mem[idx];
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: latches a fetch, inserts wait states, returns the word.
// Wait-state support is built only when INST_SRAM_WAIT_EN is defined.
module inst_sram_responder
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = "inst_rom.mif"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_valid,
  output logic        addr_err,
  output logic        stall
);

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic        rd_en, rd_bad, err_q;
  logic [31:0] rd_addr, rom_dout;

`ifdef INST_SRAM_WAIT_EN
  localparam int unsigned WAIT_CLAMP = (WAIT_CYCLES > int'(MAX_WAIT)) ? MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0]  WAIT_EFF   = 4'(WAIT_CLAMP);
  logic [3:0] cnt, cnt_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
`ifdef INST_SRAM_WAIT_EN
      cnt    <= 4'd0;
`endif
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      if (rd_en) err_q <= rd_bad;
`ifdef INST_SRAM_WAIT_EN
      cnt    <= cnt_n;
`endif
    end
  end

  // A request accepted from IDLE or RESP reads straight from the incoming
  // address when there are no wait states; otherwise WAIT reads the latched one.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
`ifdef INST_SRAM_WAIT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE, RESP: begin
        if (inst_sram_en) begin
          addr_n = inst_sram_addr;
`ifdef INST_SRAM_WAIT_EN
          cnt_n  = WAIT_EFF;
          if (WAIT_EFF == 4'd0) begin
            state_n = RESP;
            rd_en   = 1'b1;
            rd_addr = inst_sram_addr;
          end else begin
            state_n = WAIT;
          end
`else
          state_n = RESP;
          rd_en   = 1'b1;
          rd_addr = inst_sram_addr;
`endif
        end else begin
          state_n = IDLE;
        end
      end
`ifdef INST_SRAM_WAIT_EN
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = RESP;
          rd_en   = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign rd_bad = addr_bad(rd_addr, BASE_ADDR, ADDR_W);

  inst_rom #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .reset(reset),
    .re   (rd_en & ~rd_bad),
    .idx  (ADDR_W'(word_off(rd_addr, BASE_ADDR))),
    .dout (rom_dout)
  );

  assign inst_sram_rdata = err_q ? NOP_INST : rom_dout;
  assign inst_valid      = (state == RESP);
  assign addr_err        = (state == RESP) & err_q;
  assign stall           = inst_sram_en & (state != RESP);

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder; expectations follow the wait count the build enables.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE = 32'hbfc00000;
`ifdef INST_SRAM_WAIT_EN
  localparam int EW = 2;
`else
  localparam int EW = 0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        err;
  logic        stall;

  int n_vec = 0;
  int n_bad = 0;

  inst_sram_responder #(
    .ADDR_W     (10),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(2),
    .INIT_FILE  ("")
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (en),
    .inst_sram_addr (addr),
    .inst_sram_rdata(rdata),
    .inst_valid     (valid),
    .addr_err       (err),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input int i);
    return 32'h8c000000 + 32'(i) * 32'h00010003 + 32'h11;
  endfunction

  task automatic drive(input logic e, input logic [31:0] a, input logic r);
    @(negedge clk);
    en = e; addr = a; reset = r;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, BASE, 1'b1);
    drive(1'b0, BASE, 1'b1);
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
  endtask

  task automatic test_fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                            input string name);
    for (int k = 0; k <= EW; k++) begin
      drive(1'b1, a, 1'b0);
      n_vec++; if (stall !== 1'b1 || valid !== 1'b0) begin
        n_bad++; $display("FAIL %s_wait%0d: stall=%0b valid=%0b want stall=1 valid=0", name, k, stall, valid);
      end
    end
    drive(1'b0, a, 1'b0);
    n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %0b want 1", name, valid); end
    n_vec++; if (err !== exp_e) begin n_bad++; $display("FAIL %s_err: got %0b want %0b", name, err, exp_e); end
    n_vec++; if (rdata !== exp_d) begin n_bad++; $display("FAIL %s_rdata: got %h want %h", name, rdata, exp_d); end
    drive(1'b0, a, 1'b0);
    n_vec++; if (valid !== 1'b0 || err !== 1'b0 || rdata !== exp_d) begin
      n_bad++; $display("FAIL %s_after: valid=%0b err=%0b rdata=%h want 0 0 %h", name, valid, err, rdata, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k <= EW; k++) begin
        drive(1'b1, BASE + 32'(4 * j), 1'b0);
        if (j > 0 && k == 0) begin
          n_vec++; if (valid !== 1'b1 || stall !== 1'b0 || rdata !== mem_val(j - 1)) begin
            n_bad++; $display("FAIL b2b_resp%0d: valid=%0b stall=%0b rdata=%h want 1 0 %h",
                              j - 1, valid, stall, rdata, mem_val(j - 1));
          end
        end else begin
          n_vec++; if (valid !== 1'b0 || stall !== 1'b1) begin
            n_bad++; $display("FAIL b2b_wait%0d_%0d: valid=%0b stall=%0b want 0 1", j, k, valid, stall);
          end
        end
      end
    end
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b1 || err !== 1'b0 || rdata !== mem_val(2)) begin
      n_bad++; $display("FAIL b2b_resp2: valid=%0b err=%0b rdata=%h want 1 0 %h", valid, err, rdata, mem_val(2));
    end
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: valid=%0b want 0", valid); end
  endtask

  task automatic test_reset_midflight();
`ifdef INST_SRAM_WAIT_EN
    drive(1'b1, BASE + 32'd4, 1'b0);
    drive(1'b1, BASE + 32'd4, 1'b0);
    drive(1'b1, BASE + 32'd4, 1'b1);
`else
    drive(1'b1, BASE + 32'd4, 1'b0);
    drive(1'b1, BASE + 32'd4, 1'b1);
`endif
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL midreset_out: valid=%0b err=%0b rdata=%h stall=%0b want all 0", valid, err, rdata, stall);
    end
    for (int k = 0; k < EW + 2; k++) begin
      drive(1'b0, BASE, 1'b0);
      n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_idle%0d: valid=%0b want 0", k, valid); end
    end
    drive(1'b1, BASE + 32'd4, 1'b0);
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL midreset_restart: stall=%0b want 1", stall); end
    for (int k = 0; k < EW; k++) drive(1'b1, BASE + 32'd4, 1'b0);
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b1 || rdata !== mem_val(1)) begin
      n_bad++; $display("FAIL midreset_fetch: valid=%0b rdata=%h want 1 %h", valid, rdata, mem_val(1));
    end
    drive(1'b0, BASE, 1'b0);
  endtask

  task automatic test_addr_change();
    drive(1'b1, BASE + 32'd4, 1'b0);
    n_vec++; if (stall !== 1'b1 || valid !== 1'b0) begin
      n_bad++; $display("FAIL chg_req: stall=%0b valid=%0b want 1 0", stall, valid);
    end
    for (int k = 0; k < EW; k++) begin
      drive(1'b1, BASE + 32'h10, 1'b0);
      n_vec++; if (stall !== 1'b1 || valid !== 1'b0) begin
        n_bad++; $display("FAIL chg_wait%0d: stall=%0b valid=%0b want 1 0", k, stall, valid);
      end
    end
    drive(1'b1, BASE + 32'h10, 1'b0);
    n_vec++; if (valid !== 1'b1 || stall !== 1'b0 || rdata !== mem_val(1)) begin
      n_bad++; $display("FAIL chg_first: valid=%0b stall=%0b rdata=%h want 1 0 %h", valid, stall, rdata, mem_val(1));
    end
    for (int k = 0; k < EW; k++) begin
      drive(1'b1, BASE + 32'h10, 1'b0);
      n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL chg_wait2_%0d: valid=%0b want 0", k, valid); end
    end
    drive(1'b0, BASE, 1'b0);
    n_vec++; if (valid !== 1'b1 || rdata !== mem_val(4)) begin
      n_bad++; $display("FAIL chg_second: valid=%0b rdata=%h want 1 %h", valid, rdata, mem_val(4));
    end
    drive(1'b0, BASE, 1'b0);
  endtask

  initial begin
    en = 1'b0; addr = BASE; reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) dut.u_rom.mem[i] = mem_val(i);
    dut.u_rom.mem[1023] = mem_val(1023);

    test_reset();
    test_fetch(BASE,                mem_val(0),    1'b0, "fetch_w0");
    test_fetch(BASE + 32'hc,        mem_val(3),    1'b0, "fetch_w3");
    test_fetch(BASE + 32'hffc,      mem_val(1023), 1'b0, "fetch_last");
    test_fetch(32'hbfc00002,        32'h0,         1'b1, "misaligned");
    test_fetch(32'hbfc01000,        32'h0,         1'b1, "out_of_range");
    test_fetch(32'hbfbffffc,        32'h0,         1'b1, "below_base");
    test_back_to_back();
    test_reset_midflight();
    test_addr_change();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
